// File: rtl/spi_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_rx_pkg
// Shared definitions for the SPI sample receiver:
//   - default sample width and frame limit
//   - number of synchroniser stages used on every link input
//   - FSM state type and state constants (IDLE, SHIFT, CHECK, COMMIT)
// -----------------------------------------------------------------------------
package spi_rx_pkg;

   localparam int SAMPLE_W_DEF     = 12;
   localparam int SAMPLE_LIMIT_DEF = 34;
   localparam int SYNC_STAGES      = 2;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t SHIFT  = 2'd1;
   localparam state_t CHECK  = 2'd2;
   localparam state_t COMMIT = 2'd3;

endpackage

// File: rtl/spi_sample_receiver_if.sv
// -----------------------------------------------------------------------------
// spi_sample_receiver_if
// Bundles the 3-wire link and the FIFO read port of the sample receiver.
//   SCL, SS, MOSI : link clock, active-low select, data (all asynchronous)
//   rd_en         : pop request for the FIFO head
//   rd_data       : FIFO head sample
//   rd_valid      : FIFO non-empty
// Modports:
//   slave  - the receiver (consumes the link, drives the read data)
//   master - the link driver / sample consumer
// -----------------------------------------------------------------------------
interface spi_sample_receiver_if #(
   parameter int SAMPLE_W = 12
);

   logic                SCL;
   logic                SS;
   logic                MOSI;
   logic                rd_en;
   logic [SAMPLE_W-1:0] rd_data;
   logic                rd_valid;

   modport slave (
      input  SCL,
      input  SS,
      input  MOSI,
      input  rd_en,
      output rd_data,
      output rd_valid
   );

   modport master (
      output SCL,
      output SS,
      output MOSI,
      output rd_en,
      input  rd_data,
      input  rd_valid
   );

endinterface

// File: rtl/spi_rx_sync.sv
// -----------------------------------------------------------------------------
// spi_rx_sync
// Brings one asynchronous link input into the clk domain and detects edges.
//   clk, rst   : system clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronised level
//   rise, fall : one-cycle pulses on a synchronised rising / falling edge
// RESET_VAL is the idle level of the pin, so that leaving reset never
// produces a spurious edge.
// -----------------------------------------------------------------------------
module spi_rx_sync
   import spi_rx_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Synchroniser chain plus one history flop; the edge pulses compare the
   // last synchronised stage against the history flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         hist_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_sample_receiver.sv
// -----------------------------------------------------------------------------
// spi_sample_receiver
// Receive end of the 3-wire write link. Oversamples SCL/SS/MOSI on clk,
// deserialises each frame (MSB first) into a SAMPLE_W-bit sample, buffers
// samples in a FIFO_DEPTH-entry FIFO and counts committed frames up to
// SAMPLE_LIMIT, after which done asserts and further frames are dropped.
// Ports:
//   clk          : 50 MHz system clock
//   rst          : asynchronous active-low reset
//   bus          : link inputs and FIFO read port (slave modport)
//   sample_count : frames committed since reset
//   frame_err    : sticky short / overlong / overflow (/ timeout) error
//   done         : sample_count reached SAMPLE_LIMIT
// Optional feature, macro SPI_RX_TIMEOUT_EN: a watchdog aborts a frame when
// SCL stays quiet for TIMEOUT_CYCLES clk cycles inside SHIFT; the receiver
// then waits for SS to go high before accepting another frame.
// -----------------------------------------------------------------------------
module spi_sample_receiver
   import spi_rx_pkg::*;
#(
   parameter int SAMPLE_W       = SAMPLE_W_DEF,
   parameter int SAMPLE_LIMIT   = SAMPLE_LIMIT_DEF,
   parameter int FIFO_DEPTH     = 4
`ifdef SPI_RX_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1000
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_sample_receiver_if.slave bus,
   output logic [5:0]           sample_count,
   output logic                 frame_err,
   output logic                 done
);

   localparam int CNT_W = $clog2(SAMPLE_W + 2);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(SAMPLE_W);
   localparam logic [CNT_W-1:0] BITS_SAT  = CNT_W'(SAMPLE_W + 1);
   localparam logic [5:0]       LIMIT     = 6'(SAMPLE_LIMIT);
   localparam logic [PTR_W:0]   DEPTH     = (PTR_W+1)'(FIFO_DEPTH);

   logic scl_level, scl_rise, scl_fall;
   logic ss_level,  ss_rise,  ss_fall;
   logic mosi_level, mosi_rise, mosi_fall;

   state_t              state;
   logic [CNT_W-1:0]    bit_cnt;
   logic [SAMPLE_W-1:0] shreg;

   logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W:0]      fill;
   logic                fifo_full;
   logic                pop;
   logic                wr_en;
   logic                at_limit;
   logic                start_ok;

   spi_rx_sync #(.RESET_VAL(1'b0)) u_sync_scl (
      .clk(clk), .rst(rst), .din(bus.SCL),
      .level(scl_level), .rise(scl_rise), .fall(scl_fall)
   );

   spi_rx_sync #(.RESET_VAL(1'b1)) u_sync_ss (
      .clk(clk), .rst(rst), .din(bus.SS),
      .level(ss_level), .rise(ss_rise), .fall(ss_fall)
   );

   spi_rx_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(bus.MOSI),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );

   logic unused_sync;
   assign unused_sync = &{1'b0, scl_level, scl_fall, mosi_rise, mosi_fall, ss_fall};

   // FIFO status. A pop in the same cycle as a write frees the slot first,
   // so a full FIFO still accepts the sample.
   assign fifo_full   = (fill == DEPTH);
   assign bus.rd_valid = (fill != '0);
   assign bus.rd_data  = bus.rd_valid ? mem[rd_ptr] : '0;
   assign pop         = bus.rd_en && bus.rd_valid;
   assign at_limit    = (sample_count == LIMIT);
   assign wr_en       = (state == COMMIT) && !at_limit && (!fifo_full || pop);

`ifdef SPI_RX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_cnt;
   logic            wait_high;
   logic            timeout;

   // Watchdog only runs while shifting; any SCL rise or SS fall restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt <= '0;
      end else if (state != SHIFT || scl_rise || ss_fall) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_LIMIT) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign timeout = (state == SHIFT) && (wd_cnt == WD_LIMIT);

   // After an abort SS is likely still low; block restarts until it rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_high <= 1'b0;
      end else if (timeout && !ss_rise) begin
         wait_high <= 1'b1;
      end else if (ss_level) begin
         wait_high <= 1'b0;
      end
   end

   assign start_ok = !wait_high;
`else
   assign start_ok = 1'b1;
`endif

   // Frame FSM. IDLE looks at the synchronised SS level rather than the fall
   // pulse, so a frame whose SS fall lands during CHECK/COMMIT is not lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!ss_level && start_ok) begin
                  bit_cnt <= '0;
                  shreg   <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               // An SCL rise coinciding with the SS rise is still shifted in.
               if (scl_rise) begin
                  shreg <= {shreg[SAMPLE_W-2:0], mosi_level};
                  if (bit_cnt != BITS_SAT) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               if (ss_rise) begin
                  state <= CHECK;
`ifdef SPI_RX_TIMEOUT_EN
               end else if (timeout) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
`endif
               end
            end
            CHECK: begin
               if (bit_cnt == BITS_FULL) begin
                  state <= COMMIT;
               end else begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end
            end
            COMMIT: begin
               // Overflow is an error; frames past the limit are dropped quietly.
               if (!at_limit && !wr_en) begin
                  frame_err <= 1'b1;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Sample counter and done flag; done trails the count by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_count <= '0;
         done         <= 1'b0;
      end else begin
         if (wr_en) begin
            sample_count <= sample_count + 1'b1;
         end
         done <= done | at_limit;
      end
   end

   // FIFO pointers and fill level; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fill <= fill + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};
      end
   end

   // Sample storage; contents are only visible through rd_valid, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= shreg;
      end
   end

endmodule

// File: tb/tb_spi_sample_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_sample_receiver
// Directed-plus-random bench for spi_sample_receiver. A queue-based model of
// the receiver (expected FIFO contents, frame count, sticky error) is updated
// per frame from the link rules and compared against the DUT outputs.
// The SCL rate is scaled up relative to the real 100 kHz link to keep runs
// short; each half period still spans several clk cycles.
// -----------------------------------------------------------------------------
module tb_spi_sample_receiver;

   localparam int SAMPLE_W = 12;
   localparam int LIMIT    = 34;
   localparam int DEPTH    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] sample_count;
   logic       frame_err;
   logic       done;

   spi_sample_receiver_if #(.SAMPLE_W(SAMPLE_W)) bus ();

   spi_sample_receiver dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .sample_count(sample_count),
      .frame_err(frame_err),
      .done(done)
   );

   always #10 clk = ~clk;

   // Reference model state
   logic [SAMPLE_W-1:0] expQ[$];
   int                  expCount;
   logic                expErr;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one frame of nbits bits, MSB first; data changes while SCL is low.
   task automatic applyStimulus(input int nbits, input logic [15:0] value, input int half);
      @(negedge clk);
      bus.SS = 1'b0;
      repeat (half) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.MOSI = value[i];
         repeat (half) @(negedge clk);
         bus.SCL = 1'b1;
         repeat (half) @(negedge clk);
         bus.SCL = 1'b0;
      end
      repeat (half) @(negedge clk);
      bus.SS   = 1'b1;
      bus.MOSI = 1'b0;
   endtask

   // Frame outcome from the link rules: wrong length is an error, frames past
   // the limit vanish, a full buffer rejects with an error.
   task automatic modelFrame(input int nbits, input logic [15:0] value);
      if (nbits != SAMPLE_W) begin
         expErr = 1'b1;
      end else if (expCount >= LIMIT) begin
         expErr = expErr;
      end else if (expQ.size() == DEPTH) begin
         expErr = 1'b1;
      end else begin
         expQ.push_back(value[SAMPLE_W-1:0]);
         expCount++;
      end
   endtask

   task automatic sendFrame(input int nbits, input logic [15:0] value);
      applyStimulus(nbits, value, $urandom_range(4, 7));
      repeat (12) @(negedge clk);
      modelFrame(nbits, value);
   endtask

   task automatic checkState(input string tag);
      checkOutput($sformatf("%s_count", tag), 32'(sample_count), 32'(expCount));
      checkOutput($sformatf("%s_err", tag), 32'(frame_err), 32'(expErr));
      checkOutput($sformatf("%s_done", tag), 32'(done), 32'(expCount == LIMIT));
      checkOutput($sformatf("%s_valid", tag), 32'(bus.rd_valid), 32'(expQ.size() != 0));
   endtask

   // Checks the head against the model and pops one entry.
   task automatic popCheck(input string tag);
      logic [SAMPLE_W-1:0] head;
      head = (expQ.size() != 0) ? expQ[0] : '0;
      checkOutput($sformatf("%s_valid", tag), 32'(bus.rd_valid), 32'(expQ.size() != 0));
      checkOutput($sformatf("%s_data", tag), 32'(bus.rd_data), 32'(head));
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      if (expQ.size() != 0) void'(expQ.pop_front());
      @(negedge clk);
   endtask

   task automatic doReset();
      bus.SS    = 1'b1;
      bus.SCL   = 1'b0;
      bus.MOSI  = 1'b0;
      bus.rd_en = 1'b0;
      rst       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      expQ.delete();
      expCount = 0;
      expErr   = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int lat;
      logic [15:0] v;

      bus.SS    = 1'b1;
      bus.SCL   = 1'b0;
      bus.MOSI  = 1'b0;
      bus.rd_en = 1'b0;
      expCount  = 0;
      expErr    = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      checkOutput("reset_data", 32'(bus.rd_data), 32'h0);
      checkState("reset");
      doReset();

      // Single frame 0xA5C with latency measurement from SS rise
      applyStimulus(SAMPLE_W, 16'hA5C, 5);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bus.rd_valid && lat == 0) lat = k;
      end
      checkOutput("latency_le6", 32'(lat >= 1 && lat <= 6), 32'd1);
      modelFrame(SAMPLE_W, 16'hA5C);
      checkState("first");
      popCheck("first_pop");

      // Short and overlong frames, then a good one
      sendFrame(11, 16'($urandom_range(0, 2047)));
      checkState("short");
      sendFrame(13, 16'($urandom_range(0, 8191)));
      checkState("long");
      sendFrame(SAMPLE_W, 16'h123);
      checkState("after_err");
      popCheck("after_err_pop");

      // Reset in the middle of a frame
      doReset();
      bus.SS = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         bus.MOSI = 1'($urandom_range(0, 1));
         repeat (5) @(negedge clk);
         bus.SCL = 1'b1;
         repeat (5) @(negedge clk);
         bus.SCL = 1'b0;
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_data", 32'(bus.rd_data), 32'h0);
      checkOutput("midrst_valid", 32'(bus.rd_valid), 32'h0);
      checkOutput("midrst_count", 32'(sample_count), 32'h0);
      checkOutput("midrst_err", 32'(frame_err), 32'h0);
      checkOutput("midrst_done", 32'(done), 32'h0);
      doReset();
      sendFrame(SAMPLE_W, 16'hFFF);
      checkState("post_rst");
      popCheck("post_rst_pop");

      // Overflow: five frames without popping
      doReset();
      for (int i = 0; i < 5; i++) begin
         sendFrame(SAMPLE_W, 16'($urandom_range(0, 4095)));
      end
      checkState("ovf");
      for (int i = 0; i < 4; i++) begin
         popCheck($sformatf("ovf_pop%0d", i));
      end
      checkOutput("ovf_empty", 32'(bus.rd_valid), 32'h0);

      // Limit: frames 0..33 drained as they arrive, then one extra
      doReset();
      for (int i = 0; i < LIMIT; i++) begin
         sendFrame(SAMPLE_W, 16'(i));
         checkOutput($sformatf("lim%0d_done", i), 32'(done), 32'(expCount == LIMIT));
         popCheck($sformatf("lim%0d", i));
      end
      checkState("limit");
      v = 16'($urandom_range(0, 4095));
      sendFrame(SAMPLE_W, v);
      checkState("beyond");

`ifdef SPI_RX_TIMEOUT_EN
      // Stalled frame: five bits then SCL quiet past the watchdog limit
      doReset();
      bus.SS = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         bus.MOSI = 1'($urandom_range(0, 1));
         repeat (5) @(negedge clk);
         bus.SCL = 1'b1;
         repeat (5) @(negedge clk);
         bus.SCL = 1'b0;
      end
      repeat (1100) @(negedge clk);
      expErr = 1'b1;
      checkState("timeout");
      bus.SS = 1'b1;
      repeat (12) @(negedge clk);
      checkState("timeout_idle");
      sendFrame(SAMPLE_W, 16'($urandom_range(0, 4095)));
      checkState("timeout_next");
      popCheck("timeout_pop");
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

endmodule
